nanofs_sb_reader: RTL
=====================

NANOFS_SB_READER -- requirements
Module: nanofs_sb_reader

Interface
REQ-001 SHALL have parameter MAGIC, 16 bits, default 16'h4E61: required superblock magic; byte 0 = MAGIC[7:0], byte 1 = MAGIC[15:8].
REQ-002 SHALL have parameter BSIZE_CODE, 8 bits, default 8'h01: required block-size byte.
REQ-003 SHALL have parameter NUM_COPIES, default 2, range 1..4: number of superblock copies tried.
REQ-004 SHALL have parameter COPY_STRIDE, 32 bits, default 32'h1: block distance between copies.
REQ-005 SHALL have parameter MAX_RETRIES, default 2, range 0..7: extra attempts per copy after an SPI error or timeout.
REQ-006 SHALL have parameter CHECKSUM_EN, default 1: byte 8 SHALL equal the XOR of bytes 0..7.
REQ-007 SHALL have parameter TIMEOUT, default 65535: maximum cycles spent in any wait state.
REQ-008 Ports:
 clk  in  1  clock; all logic on rising edge.
 reset  in  1  synchronous, active-high.
 start  in  1  level request; sampled only in IDLE.
 begin_address  in  32  block address of copy 0.
 done  out  1  high in SUCCESS or ERROR.
 success  out  1  valid superblock found.
 err_signal  out  1  all copies failed.
 err_code  out  3  cause of the last failure.
 copy_idx  out  2  copy currently or last examined.
 start_reg  out  32  bytes 4..7, little-endian, of the accepted copy.
 spi_r_block  out  1  block-open request, held for the whole block read.
 spi_r_byte  out  1  one-cycle byte-advance pulse.
 spi_busy  in  1  SPI engine busy.
 spi_err  in  1  SPI engine error.
 spi_block_addr  out  32  begin_address + copy_idx*COPY_STRIDE, 32-bit wrap.
 spi_data_out  in  8  current byte, valid while spi_busy=0.
 debug_state  out  4  current state encoding.

Function
REQ-009 States: IDLE, READ_BLOCK, WAIT_BLOCK, READ_DATA, READ_BYTE, WAIT_BYTE, CHECK, RETRY, NEXT_COPY, SUCCESS, ERROR.
REQ-010 IDLE: clear byte counter, retry counter, copy_idx and checksum accumulator; start=1 -> READ_BLOCK.
REQ-011 READ_BLOCK: when spi_busy=0, assert spi_r_block and go to WAIT_BLOCK; otherwise stay.
REQ-012 WAIT_BLOCK, READ_DATA, READ_BYTE and WAIT_BYTE SHALL hold spi_r_block=1; WAIT_BLOCK goes to READ_DATA when spi_busy=0.
REQ-013 READ_DATA, byte counter k: capture spi_data_out to slot k for k<=7 (k=3 reserved, discarded) and XOR it into the accumulator.
REQ-014 READ_DATA transitions: k=8 with CHECKSUM_EN=1 compares byte 8 with the accumulator and goes to CHECK; k=8 with CHECKSUM_EN=0, or k=9, goes to CHECK; otherwise goes to READ_BYTE.
REQ-015 READ_BYTE: pulse spi_r_byte for exactly one cycle, increment k, then go to WAIT_BYTE.
REQ-016 WAIT_BYTE: spi_busy=0 -> READ_DATA.
REQ-017 CHECK, one cycle, priority order: magic mismatch -> err_code 1; size mismatch -> 2; checksum mismatch -> 3.
REQ-018 CHECK outcome: any mismatch goes to NEXT_COPY without retry; no mismatch goes to SUCCESS.
REQ-019 spi_err=1 in any read or wait state SHALL set err_code 4 and go to RETRY.
REQ-020 A wait-state cycle count reaching TIMEOUT SHALL set err_code 5 and go to RETRY.
REQ-021 The wait-state cycle count SHALL clear on every state change.
REQ-022 RETRY: deassert spi_r_block for one cycle and clear k and the accumulator.
REQ-023 RETRY exit: if retries < MAX_RETRIES, increment retries and go to READ_BLOCK; otherwise go to NEXT_COPY.
REQ-024 NEXT_COPY: if copy_idx < NUM_COPIES-1, increment copy_idx, clear retries, k and the accumulator, then go to READ_BLOCK; otherwise go to ERROR.
REQ-025 SUCCESS: success=1, done=1, err_code=0; start_reg holds the accepted copy's value.
REQ-026 ERROR: err_signal=1, done=1; err_code holds the last failure cause.
REQ-027 SUCCESS and ERROR SHALL hold until start=0, then go to IDLE; outputs SHALL remain stable while held.
REQ-028 start changes outside IDLE, SUCCESS and ERROR SHALL be ignored.
REQ-029 start_reg SHALL update only on the transition into SUCCESS; the value from a failed copy SHALL never appear.
REQ-030 Unused state encodings SHALL go to IDLE.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge, including mid-read.
REQ-032 Reset values: spi_r_block, spi_r_byte, done, success and err_signal = 0; err_code = 0, copy_idx = 0, start_reg = 0.
REQ-033 The first start after reset SHALL begin at copy 0.

Verification
REQ-034 Copy 0 bytes 61 4E 01 00 10 20 30 40 + checksum -> success=1, start_reg=32'h40302010, copy_idx=0, spi_r_byte pulsed exactly 8 times.
REQ-035 Copy 0 byte0=00, copy 1 valid -> copy 1 read at begin_address+1, success=1, copy_idx=1.
REQ-036 Both copies have block size 02 -> err_signal=1, err_code=2, copy_idx=1, start_reg=0.
REQ-037 spi_err during copy 0 on 2 attempts, third attempt clean -> success=1, copy_idx=0.
REQ-038 spi_busy stuck high with TIMEOUT=16 -> after 3 attempts per copy, err_signal=1, err_code=5.
REQ-039 reset asserted in WAIT_BYTE -> next cycle IDLE with all outputs 0; a new start completes normally.

Source files
------------

// File: rtl/nanofs_sb_reader_if.sv
// nanofs_sb_reader_if: block/byte read handshake between the superblock reader and the SPI engine
interface nanofs_sb_reader_if;
    logic        spi_r_block;
    logic        spi_r_byte;
    logic        spi_busy;
    logic        spi_err;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_out;
    modport master(output spi_r_block, spi_r_byte, spi_block_addr, input spi_busy, spi_err, spi_data_out);
    modport slave(input spi_r_block, spi_r_byte, spi_block_addr, output spi_busy, spi_err, spi_data_out);
endinterface

// File: rtl/nanofs_sb_reader.sv
// nanofs_sb_reader: reads and validates redundant NanoFS superblock copies over SPI, with retries and timeouts
module nanofs_sb_reader #(
    parameter logic [15:0] MAGIC       = 16'h4E61,
    parameter logic [7:0]  BSIZE_CODE  = 8'h01,
    parameter int          NUM_COPIES  = 2,
    parameter logic [31:0] COPY_STRIDE = 32'h1,
    parameter int          MAX_RETRIES = 2,
    parameter bit          CHECKSUM_EN = 1,
    parameter int          TIMEOUT     = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               begin_address,
    output logic                      done,
    output logic                      success,
    output logic                      err_signal,
    output logic [2:0]                err_code,
    output logic [1:0]                copy_idx,
    output logic [31:0]               start_reg,
    output logic [3:0]                debug_state,
    nanofs_sb_reader_if.master        spi
);
    typedef enum logic [3:0] {
        IDLE, READ_BLOCK, WAIT_BLOCK, READ_DATA, READ_BYTE, WAIT_BYTE,
        CHECK, RETRY, NEXT_COPY, SUCCESS, ERROR
    } state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t        state, ns;
    logic [3:0]    k;
    logic [2:0]    retries, ec;
    logic [7:0]    acc, b0, b1, b2;
    logic [31:0]   payload;
    logic          chk_bad, tmo, bad_magic, bad_size;
    logic [TW-1:0] wcnt;
    assign debug_state = state;
    assign spi.spi_block_addr = begin_address + 32'(copy_idx) * COPY_STRIDE;
    always_comb begin
        tmo = state inside {READ_BLOCK, WAIT_BLOCK, WAIT_BYTE} && wcnt == TW'(TIMEOUT - 1);
        bad_magic = {b1, b0} != MAGIC;
        bad_size = b2 != BSIZE_CODE;
        ns = state;
        ec = err_code;
        if (state inside {READ_BLOCK, WAIT_BLOCK, READ_DATA, READ_BYTE, WAIT_BYTE} && spi.spi_err) begin
            ns = RETRY;
            ec = 3'd4;
        end else begin
            case (state)
                IDLE:       ns = start ? READ_BLOCK : IDLE;
                READ_BLOCK: ns = spi.spi_busy ? READ_BLOCK : WAIT_BLOCK;
                WAIT_BLOCK: ns = spi.spi_busy ? WAIT_BLOCK : READ_DATA;
                READ_DATA:  ns = k >= 4'd8 ? CHECK : READ_BYTE;
                READ_BYTE:  ns = WAIT_BYTE;
                WAIT_BYTE:  ns = spi.spi_busy ? WAIT_BYTE : READ_DATA;
                CHECK: begin
                    ns = (bad_magic || bad_size || chk_bad) ? NEXT_COPY : SUCCESS;
                    ec = bad_magic ? 3'd1 : bad_size ? 3'd2 : chk_bad ? 3'd3 : 3'd0;
                end
                RETRY:      ns = retries < 3'(MAX_RETRIES) ? READ_BLOCK : NEXT_COPY;
                NEXT_COPY:  ns = copy_idx < 2'(NUM_COPIES - 1) ? READ_BLOCK : ERROR;
                SUCCESS,
                ERROR:      ns = start ? state : IDLE;
                default:    ns = IDLE;
            endcase
            // a wait state that would stay put once more has used up its budget
            if (tmo && ns == state) begin
                ns = RETRY;
                ec = 3'd5;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k <= '0;
            retries <= '0;
            acc <= '0;
            b0 <= '0;
            b1 <= '0;
            b2 <= '0;
            payload <= '0;
            chk_bad <= 1'b0;
            wcnt <= '0;
            copy_idx <= '0;
            err_code <= '0;
            start_reg <= '0;
            done <= 1'b0;
            success <= 1'b0;
            err_signal <= 1'b0;
            spi.spi_r_block <= 1'b0;
            spi.spi_r_byte <= 1'b0;
        end else begin
            state <= ns;
            err_code <= ec;
            wcnt <= ns == state ? wcnt + 1'b1 : '0;
            spi.spi_r_block <= ns inside {WAIT_BLOCK, READ_DATA, READ_BYTE, WAIT_BYTE};
            spi.spi_r_byte <= ns == READ_BYTE;
            done <= ns inside {SUCCESS, ERROR};
            success <= ns == SUCCESS;
            err_signal <= ns == ERROR;
            // byte 3 is reserved: it only feeds the checksum
            if (state == READ_DATA) begin
                if (k == 4'd0) b0 <= spi.spi_data_out;
                if (k == 4'd1) b1 <= spi.spi_data_out;
                if (k == 4'd2) b2 <= spi.spi_data_out;
                if (k[3:2] == 2'b01) payload[{k[1:0], 3'b000} +: 8] <= spi.spi_data_out;
                if (k < 4'd8) acc <= acc ^ spi.spi_data_out;
                if (k == 4'd8) chk_bad <= CHECKSUM_EN && spi.spi_data_out != acc;
            end
            if (state == READ_BYTE) k <= k + 1'b1;
            if (state inside {IDLE, RETRY, NEXT_COPY}) begin
                k <= '0;
                acc <= '0;
            end
            if (state == IDLE) begin
                retries <= '0;
                copy_idx <= '0;
            end
            if (state == RETRY && ns == READ_BLOCK) retries <= retries + 1'b1;
            if (state == NEXT_COPY && ns == READ_BLOCK) begin
                copy_idx <= copy_idx + 1'b1;
                retries <= '0;
            end
            if (state == CHECK && ns == SUCCESS) start_reg <= payload;
        end
    end
endmodule
